// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: datapath width, bubble encoding,
// default boot address and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Sequential successor address; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control from decode/EX, the imem read port and the IF/ID outputs.
// The master side is the fetch stage; the slave side is its environment.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            boot_hold;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc4;
  logic            if_id_valid;
  logic            fetch_fault;

  modport master (
    input  boot_hold, stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, fetch_fault
  );

  modport slave (
    output boot_hold, stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, fetch_fault
  );

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble (NOP, invalid) but keeps the
// PC fields, and takes priority over load.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4_q;
  logic            valid_q;

  // IF/ID storage with bubble insertion on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= {XLEN{1'b0}};
      pc4_q   <= {XLEN{1'b0}};
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and BOOT/RUN/HALT FSM.
// Define MISALIGN_CHK_EN to trap misaligned redirect targets into HALT with a sticky fault.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4;
  logic            if_load;
  logic            if_flush;
`ifdef MISALIGN_CHK_EN
  logic            fault_q;
  logic            fault_set;
`endif

  assign pc4           = pc_plus4(pc_q);
  assign bus.imem_addr = pc_q;

  // Next-state, next-PC and IF/ID control; redirect outranks stall in RUN.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_load   = 1'b0;
    if_flush  = 1'b0;
`ifdef MISALIGN_CHK_EN
    fault_set = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        if (!bus.boot_hold) begin
          state_d = RUN;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (bus.redirect) begin
          pc_d     = bus.redirect_pc;
          if_flush = 1'b1;
`ifdef MISALIGN_CHK_EN
          if (bus.redirect_pc[1:0] != 2'b00) begin
            fault_set = 1'b1;
            state_d   = HALT;
          end else begin
            state_d   = RUN;
          end
`else
          state_d  = RUN;
`endif
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          pc_d    = pc4;
          if_load = 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef MISALIGN_CHK_EN
  // Sticky misaligned-target fault; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (if_load),
    .flush_i (if_flush),
    .instr_i (bus.imem_rdata),
    .pc_i    (pc_q),
    .pc4_i   (pc4),
    .instr_o (bus.if_id_instr),
    .pc_o    (bus.if_id_pc),
    .pc4_o   (bus.if_id_pc4),
    .valid_o (bus.if_id_valid)
  );

endmodule
